hardened_sum_accumulator: RTL and testbench



---
 rtl/hardened_acc_pkg.sv | 21 ++
 rtl/hardened_sum_accumulator_acc_lane.sv | 45 ++++
 rtl/hardened_sum_accumulator.sv | 114 +++++++++++
 tb/tb_hardened_sum_accumulator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hardened_acc_pkg.sv
// Shared types and constants for the hardened sum accumulator.
//   state_t   : top-level FSM states
//   ADDER_W   : width of one adder result ({cout, sum})
//   CNT_W     : width of the per-frame sample counter (COUNT up to 255)
//   acc_w_ok  : legality check for the accumulator width
package hardened_acc_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    HOLD  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int ADDER_W = 5;
  localparam int CNT_W   = 8;

  function automatic bit acc_w_ok(input int w);
    return (w >= ADDER_W) && (w <= 32);
  endfunction

endpackage

// File: rtl/hardened_sum_accumulator_acc_lane.sv
// One storage lane: accumulator plus sample counter.
// With INVERT=1 the registers hold the bit-inverse of the true values, so a
// stuck or flipped bit shows up as a disagreement against the plain lane.
// Each lane advances from its own stored contents, so a corruption persists
// instead of being healed by the other copy.
//   clk, rst : clock, synchronous active-high reset
//   clr      : return to the empty-frame value (acc=0, cnt=0)
//   load     : add sample to acc and increment cnt
//   sample   : zero-extended adder result
//   acc, cnt : decoded (true-polarity) contents
module acc_lane
  import hardened_acc_pkg::*;
#(
  parameter int ACC_W  = 12,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [ACC_W-1:0] sample,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [ACC_W-1:0] ACC_MASK = {ACC_W{INVERT}};
  localparam logic [CNT_W-1:0] CNT_MASK = {CNT_W{INVERT}};

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;

  assign acc = acc_q ^ ACC_MASK;
  assign cnt = cnt_q ^ CNT_MASK;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_q <= ACC_MASK;
      cnt_q <= CNT_MASK;
    end else if (load) begin
      acc_q <= (acc + sample) ^ ACC_MASK;
      cnt_q <= (cnt + 1'b1) ^ CNT_MASK;
    end
  end

endmodule

// File: rtl/hardened_sum_accumulator.sv
// Frame accumulator for adder results with duplicated, inverted shadow state.
// Accepts COUNT results ({in_cout, in_sum}) and presents their sum (mod
// 2^ACC_W) on a valid/ready output. Any disagreement between primary and
// shadow lanes latches out_fault and halts the block until rst.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake; in_sum, in_cout carry the sample
//   out_valid/out_ready    : output handshake; out_acc carries the frame total
//   out_fault              : sticky duplication mismatch
//   busy                   : frame partially filled or total pending
//
// state | meaning
// ACCUM | collecting samples, in_ready=1
// HOLD  | frame total presented, waiting for out_ready
// FAULT | lanes disagreed; halted until rst
module hardened_sum_accumulator
  import hardened_acc_pkg::*;
#(
  parameter int COUNT = 8,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_fault,
  output logic             busy
);

  if (!acc_w_ok(ACC_W)) begin : g_bad_acc_w
    $error("hardened_sum_accumulator: ACC_W out of range 5..32");
  end
  if ((COUNT < 1) || (COUNT > 255)) begin : g_bad_count
    $error("hardened_sum_accumulator: COUNT out of range 1..255");
  end

  localparam logic [CNT_W-1:0] COUNT_V = CNT_W'(COUNT);

  state_t           state_q, state_d;
  logic             lane_clr, lane_load, mismatch;
  logic [ACC_W-1:0] sample;
  logic [ACC_W-1:0] p_acc, s_acc;
  logic [CNT_W-1:0] p_cnt, s_cnt;

  assign sample = ACC_W'({in_cout, in_sum});

  acc_lane #(.ACC_W(ACC_W), .INVERT(1'b0)) u_primary (
    .clk    (clk),
    .rst    (rst),
    .clr    (lane_clr),
    .load   (lane_load),
    .sample (sample),
    .acc    (p_acc),
    .cnt    (p_cnt)
  );

  acc_lane #(.ACC_W(ACC_W), .INVERT(1'b1)) u_shadow (
    .clk    (clk),
    .rst    (rst),
    .clr    (lane_clr),
    .load   (lane_load),
    .sample (sample),
    .acc    (s_acc),
    .cnt    (s_cnt)
  );

  assign mismatch = (state_q != FAULT) && ((p_acc != s_acc) || (p_cnt != s_cnt));

  // rst gating keeps in_ready low for the whole reset pulse, including the
  // cycles after the first reset edge where state is already ACCUM.
  assign in_ready  = (state_q == ACCUM) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_acc   = (state_q == HOLD) ? p_acc : '0;
  assign out_fault = (state_q == FAULT);
  assign busy      = (state_q == HOLD) || ((state_q == ACCUM) && (p_cnt != '0));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  // Detection wins over any handshake in the same cycle: the lanes are not
  // updated, so the sample is not consumed and the total is not delivered.
  always_comb begin
    state_d   = state_q;
    lane_clr  = 1'b0;
    lane_load = 1'b0;
    if (mismatch) begin
      state_d = FAULT;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid && in_ready) begin
            lane_load = 1'b1;
            if (CNT_W'(p_cnt + 1'b1) == COUNT_V) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            lane_clr = 1'b1;
            state_d  = ACCUM;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_hardened_sum_accumulator.sv
module tb_hardened_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance: COUNT=4, ACC_W=12
  logic        in_valid, in_ready, in_cout, out_valid, out_ready, out_fault, busy;
  logic [3:0]  in_sum;
  logic [11:0] out_acc;

  // wrap instance: COUNT=2, ACC_W=5
  logic        w_in_valid, w_in_ready, w_in_cout, w_out_valid, w_out_ready, w_out_fault, w_busy;
  logic [3:0]  w_in_sum;
  logic [4:0]  w_out_acc;

  hardened_sum_accumulator #(.COUNT(4), .ACC_W(12)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_fault(out_fault), .busy(busy)
  );

  hardened_sum_accumulator #(.COUNT(2), .ACC_W(5)) dut_w (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_sum(w_in_sum), .in_cout(w_in_cout),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_acc(w_out_acc),
    .out_fault(w_out_fault), .busy(w_busy)
  );

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_w_q[$];
  logic [11:0] fault_val;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: pop one expected total per completed output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_val("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_val("frame_total", 32'(out_acc), exp_q.pop_front());
      delivered++;
    end
    if (!rst && w_out_valid && w_out_ready) begin
      check_val("w_sb_pending", 32'(exp_w_q.size() != 0), 1);
      if (exp_w_q.size() != 0) check_val("w_frame_total", 32'(w_out_acc), exp_w_q.pop_front());
    end
  end

  // present one sample, wait (bounded) for acceptance, return just after the accept edge
  task automatic send_sample(input logic [4:0] v, output int stalls);
    in_valid = 1'b1;
    {in_cout, in_sum} = v;
    stalls = 0;
    @(negedge clk);
    while (!in_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!in_ready) check_val("accept_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [4:0] a, b, c, d);
    int st;
    exp_q.push_back(32'((12'(a) + 12'(b) + 12'(c) + 12'(d)) & 12'hFFF));
    send_sample(a, st);
    send_sample(b, st);
    send_sample(c, st);
    send_sample(d, st);
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    int idle_cnt;
    rst = 1'b1;
    in_valid = 1'b0; in_sum = '0; in_cout = 1'b0; out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_sum = '0; w_in_cout = 1'b0; w_out_ready = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready_hi", 32'(in_ready), 0);
    check_val("rst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(in_ready), 1);
    check_val("post_rst_out_valid", 32'(out_valid), 0);
    check_val("post_rst_out_acc", 32'(out_acc), 0);
    check_val("post_rst_fault", 32'(out_fault), 0);
    check_val("post_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;

    // basic frame and latency: 3 + 8 + 16 + 31 = 58
    send_frame(5'd3, 5'd8, 5'b10000, 5'b11111);
    @(negedge clk);
    check_val("lat_out_valid", 32'(out_valid), 1);
    check_val("lat_out_acc", 32'(out_acc), 58);
    check_val("lat_fault", 32'(out_fault), 0);
    check_val("hold_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("after_hs_valid", 32'(out_valid), 0);
    check_val("after_hs_ready", 32'(in_ready), 1);
    check_val("after_hs_busy", 32'(busy), 0);
    @(posedge clk);
    #1;

    // backpressure: hold the total for 5 cycles while in_valid pulses
    out_ready = 1'b0;
    send_frame(5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      {in_cout, in_sum} = 5'd31;
      @(negedge clk);
      check_val("bp_out_valid", 32'(out_valid), 1);
      check_val("bp_out_acc", 32'(out_acc), 10);
      check_val("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("bp_release_ready", 32'(in_ready), 1);
    check_val("bp_release_busy", 32'(busy), 0);
    @(posedge clk);
    #1;

    // throughput: 1..8 back-to-back, exactly one stall between frames
    exp_q.push_back(32'd10);
    exp_q.push_back(32'd26);
    idle_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      send_sample(5'(i), st);
      idle_cnt += st;
    end
    in_valid = 1'b0;
    check_val("tput_idle_cycles", 32'(idle_cnt), 1);
    idle(3);

    // reset mid-frame discards the partial sum
    send_sample(5'd5, st);
    send_sample(5'd5, st);
    in_valid = 1'b0;
    pulse_reset();
    @(negedge clk);
    check_val("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    send_frame(5'd1, 5'd1, 5'd1, 5'd1);
    idle(3);

    // fault: flip one shadow accumulator bit for one cycle mid-frame
    send_sample(5'd2, st);
    send_sample(5'd3, st);
    in_valid = 1'b1;
    {in_cout, in_sum} = 5'd7;
    fault_val = dut.u_shadow.acc_q ^ 12'h010;
    force dut.u_shadow.acc_q = fault_val;
    @(negedge clk);
    check_val("fault_not_yet", 32'(out_fault), 0);
    @(posedge clk);
    #1 release dut.u_shadow.acc_q;
    @(negedge clk);
    check_val("fault_set", 32'(out_fault), 1);
    check_val("fault_in_ready", 32'(in_ready), 0);
    check_val("fault_out_valid", 32'(out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 in_valid = i[0];
    end
    @(negedge clk);
    check_val("fault_sticky", 32'(out_fault), 1);
    check_val("fault_sticky_ready", 32'(in_ready), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    pulse_reset();
    @(negedge clk);
    check_val("fault_cleared", 32'(out_fault), 0);
    @(posedge clk);
    #1;
    send_frame(5'd4, 5'd5, 5'd6, 5'd7);
    idle(3);

    // wrap: ACC_W=5, 31 + 31 = 62 -> 30
    exp_w_q.push_back(32'd30);
    w_in_valid = 1'b1;
    {w_in_cout, w_in_sum} = 5'd31;
    st = 0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      while (!w_in_ready && st < 50) begin
        st++;
        @(negedge clk);
      end
      if (!w_in_ready) check_val("w_accept_timeout", 32'(w_in_ready), 1);
      @(posedge clk);
      #1;
    end
    w_in_valid = 1'b0;
    @(negedge clk);
    check_val("w_out_valid", 32'(w_out_valid), 1);
    check_val("w_out_acc", 32'(w_out_acc), 30);
    idle(3);

    check_val("sb_drained", 32'(exp_q.size()), 0);
    check_val("w_sb_drained", 32'(exp_w_q.size()), 0);
    check_val("frames_delivered", 32'(delivered), 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
